// File: rtl/softmax_pkg.sv
// Shared types for the softmax argmax collector: value format, FSM states, linear conversion.
package softmax_pkg;

  localparam int EXP_W  = 4;
  localparam int MANT_W = 3;
  localparam int LIN_W  = 19;

  typedef struct packed {
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } sm_val_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } sm_state_t;

  // Hidden leading one above the mantissa, shifted by the exponent.
  function automatic logic [LIN_W-1:0] to_linear(input sm_val_t v);
    logic [LIN_W-1:0] w_base;
    w_base = {{(LIN_W-MANT_W-1){1'b0}}, 1'b1, v.mant};
    return w_base << v.exp;
  endfunction

endpackage

// File: rtl/sm_val_compare.sv
// Strict greater-than of two (exp, mant) values plus linear conversion of the first operand.
module sm_val_compare
  import softmax_pkg::*;
(
  input  sm_val_t          i_a,
  input  sm_val_t          i_b,
  output logic             o_gt,
  output logic [LIN_W-1:0] o_a_lin
);

  // Field order {exp, mant} makes the packed compare exponent-first.
  assign o_gt    = (i_a > i_b);
  assign o_a_lin = to_linear(i_a);

endmodule

// File: rtl/softmax_argmax_collector.sv
// Collects one frame of pseudo-softmax results: argmax, saturating linear sum, beat count.
// Optional out_conf majority flag is enabled by defining SOFTMAX_CONF_FLAG_EN.
//
// state    | meaning
// ST_IDLE  | waiting for the first beat of a frame
// ST_ACCUM | frame open, accumulating beats
// ST_HOLD  | record presented on out_*, waiting for out_ready
module softmax_argmax_collector
  import softmax_pkg::*;
#(
  parameter int MAX_CLASSES = 8,
  parameter int IDX_W       = 3,
  parameter int SUM_W       = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_exp,
  input  logic [2:0]       in_mant,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [3:0]       out_exp,
  output logic [2:0]       out_mant,
  output logic [SUM_W-1:0] out_sum,
  output logic [IDX_W:0]   out_count,
  output logic             out_ovf
`ifdef SOFTMAX_CONF_FLAG_EN
  ,
  output logic             out_conf
`endif
);

  localparam int ACC_W = ((SUM_W > LIN_W) ? SUM_W : LIN_W) + 1;
  localparam int CNT_W = IDX_W + 1;
  localparam logic [ACC_W-1:0] SUM_MAX = {{(ACC_W-SUM_W){1'b0}}, {SUM_W{1'b1}}};
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CLASSES);

  sm_state_t        r_state;
  sm_val_t          r_max;
  logic [IDX_W-1:0] r_idx;
  logic [SUM_W-1:0] r_sum;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;
  logic             r_in_ready;
  logic             r_out_valid;

  sm_val_t          w_beat;
  sm_val_t          w_max_next;
  logic             w_gt;
  logic [LIN_W-1:0] w_lin;
  logic             w_first;
  logic [ACC_W-1:0] w_sum_raw;
  logic             w_sat;
  logic [SUM_W-1:0] w_sum_next;
  logic [IDX_W-1:0] w_idx_next;
  logic [CNT_W-1:0] w_count_next;
  logic             w_full;
  logic             w_close;
  logic             w_ovf_next;
  logic             w_accept;

  assign w_beat = {in_exp, in_mant};

  sm_val_compare u_cmp (
    .i_a     (w_beat),
    .i_b     (r_max),
    .o_gt    (w_gt),
    .o_a_lin (w_lin)
  );

  // The first beat of a frame starts from zero regardless of stale registers.
  assign w_first      = (r_state == ST_IDLE);
  assign w_sum_raw    = (w_first ? '0 : ACC_W'(r_sum)) + ACC_W'(w_lin);
  assign w_sat        = (w_sum_raw > SUM_MAX);
  assign w_sum_next   = w_sat ? SUM_MAX[SUM_W-1:0] : w_sum_raw[SUM_W-1:0];
  assign w_max_next   = (w_first || w_gt) ? w_beat : r_max;
  assign w_idx_next   = w_first ? '0 : (w_gt ? r_count[IDX_W-1:0] : r_idx);
  assign w_count_next = w_first ? CNT_W'(1) : r_count + CNT_W'(1);
  assign w_full       = (w_count_next == CNT_MAX);
  assign w_close      = in_last || w_full;
  assign w_ovf_next   = (!w_first && r_ovf) || w_sat || (w_full && !in_last);
  assign w_accept     = in_valid && r_in_ready;

`ifdef SOFTMAX_CONF_FLAG_EN
  logic             r_conf;
  logic             w_conf_next;
  assign w_conf_next = ({1'b0, to_linear(w_max_next), 1'b0} > (LIN_W+2)'(w_sum_next));
  assign out_conf    = r_conf;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_max       <= '0;
      r_idx       <= '0;
      r_sum       <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
`ifdef SOFTMAX_CONF_FLAG_EN
      r_conf      <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE, ST_ACCUM: begin
          if (w_accept) begin
            r_max   <= w_max_next;
            r_idx   <= w_idx_next;
            r_sum   <= w_sum_next;
            r_count <= w_count_next;
            r_ovf   <= w_ovf_next;
`ifdef SOFTMAX_CONF_FLAG_EN
            r_conf  <= w_conf_next;
`endif
            if (w_close) begin
              r_state     <= ST_HOLD;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= ST_ACCUM;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_idx   = r_idx;
  assign out_exp   = r_max.exp;
  assign out_mant  = r_max.mant;
  assign out_sum   = r_sum;
  assign out_count = r_count;
  assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_softmax_argmax_collector.sv
// Randomised and directed bench for softmax_argmax_collector (SUM_W=24 and SUM_W=16 instances).
module tb_softmax_argmax_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_last, out_ready;
  logic [3:0]  in_exp;
  logic [2:0]  in_mant;

  logic        a_in_ready, a_out_valid, a_ovf;
  logic [2:0]  a_idx, a_mant;
  logic [3:0]  a_exp, a_count;
  logic [23:0] a_sum;
  logic        b_in_ready, b_out_valid, b_ovf;
  logic [2:0]  b_idx, b_mant;
  logic [3:0]  b_exp, b_count;
  logic [15:0] b_sum;
`ifdef SOFTMAX_CONF_FLAG_EN
  logic        a_conf, b_conf;
`endif

  always #5 clk = ~clk;

  softmax_argmax_collector #(.MAX_CLASSES(8), .IDX_W(3), .SUM_W(24)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_exp(in_exp), .in_mant(in_mant), .in_last(in_last),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_idx(a_idx),
    .out_exp(a_exp), .out_mant(a_mant), .out_sum(a_sum),
    .out_count(a_count), .out_ovf(a_ovf)
`ifdef SOFTMAX_CONF_FLAG_EN
    , .out_conf(a_conf)
`endif
  );

  softmax_argmax_collector #(.MAX_CLASSES(8), .IDX_W(3), .SUM_W(16)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_exp(in_exp), .in_mant(in_mant), .in_last(in_last),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_idx(b_idx),
    .out_exp(b_exp), .out_mant(b_mant), .out_sum(b_sum),
    .out_count(b_count), .out_ovf(b_ovf)
`ifdef SOFTMAX_CONF_FLAG_EN
    , .out_conf(b_conf)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  typedef struct {
    int     idx, e, m, count;
    longint sum;
    bit     ovf, conf;
  } rec_t;

  int q_e[$];
  int q_m[$];
  bit frame_forced;

  // Reference: argmax by (exp, mant) with first occurrence winning, total mass clipped.
  function automatic rec_t model(input int sw, input bit forced);
    rec_t   r;
    longint tot = 0;
    longint mx;
    int     best = 0;
    mx = (longint'(1) << sw) - 1;
    foreach (q_e[i]) begin
      tot += longint'(8 + q_m[i]) << q_e[i];
      if (q_e[i] * 8 + q_m[i] > q_e[best] * 8 + q_m[best]) best = i;
    end
    r.idx   = best;
    r.e     = q_e[best];
    r.m     = q_m[best];
    r.count = q_e.size();
    r.sum   = (tot > mx) ? mx : tot;
    r.ovf   = (tot > mx) || forced;
    r.conf  = (2 * (longint'(8 + q_m[best]) << q_e[best])) > r.sum;
    return r;
  endfunction

  task automatic check_rec(input string tag);
    rec_t ea, eb;
    ea = model(24, frame_forced);
    eb = model(16, frame_forced);
    chk({tag, ".valid"}, a_out_valid, 1);
    chk({tag, ".ready"}, a_in_ready, 0);
    chk({tag, ".idx"},   a_idx,   ea.idx);
    chk({tag, ".exp"},   a_exp,   ea.e);
    chk({tag, ".mant"},  a_mant,  ea.m);
    chk({tag, ".sum"},   a_sum,   32'(ea.sum));
    chk({tag, ".count"}, a_count, ea.count);
    chk({tag, ".ovf"},   a_ovf,   ea.ovf);
    chk({tag, ".b_valid"}, b_out_valid, 1);
    chk({tag, ".b_idx"},   b_idx,   eb.idx);
    chk({tag, ".b_sum"},   b_sum,   32'(eb.sum));
    chk({tag, ".b_ovf"},   b_ovf,   eb.ovf);
`ifdef SOFTMAX_CONF_FLAG_EN
    chk({tag, ".conf"},   a_conf, ea.conf);
    chk({tag, ".b_conf"}, b_conf, eb.conf);
`endif
  endtask

  // Present one beat and hold it until accepted (bounded wait).
  task automatic send(input int e, input int m, input bit last);
    int n = 0;
    in_valid = 1'b1;
    in_exp   = 4'(e);
    in_mant  = 3'(m);
    in_last  = last;
    while (!a_in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!a_in_ready) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    q_e.push_back(e);
    q_m.push_back(m);
    frame_forced = !last && (q_e.size() == 8);
    if (!last && q_e.size() < 8) chk("valid_early", a_out_valid, 0);
  endtask

  // Expects the record to be valid already; stalls, then completes the handshake.
  task automatic collect(input int stall, input string tag);
    out_ready = 1'b0;
    for (int k = 0; k < stall; k++) begin
      check_rec({tag, ".stall"});
      @(posedge clk); #1;
    end
    check_rec(tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, ".post_valid"}, a_out_valid, 0);
    chk({tag, ".post_ready"}, a_in_ready, 1);
    q_e.delete();
    q_m.delete();
    frame_forced = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".ready"}, a_in_ready, 1);
    chk({tag, ".valid"}, a_out_valid, 0);
    chk({tag, ".idx"},   a_idx, 0);
    chk({tag, ".exp"},   a_exp, 0);
    chk({tag, ".mant"},  a_mant, 0);
    chk({tag, ".sum"},   a_sum, 0);
    chk({tag, ".count"}, a_count, 0);
    chk({tag, ".ovf"},   a_ovf, 0);
    chk({tag, ".b_sum"}, b_sum, 0);
`ifdef SOFTMAX_CONF_FLAG_EN
    chk({tag, ".conf"},  a_conf, 0);
`endif
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    in_exp = '0; in_mant = '0;
    frame_forced = 1'b0;
    #1;
    chk_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Basic frame: max at index 1, sum 44+128+30.
    send(2, 3, 0); send(4, 0, 0); send(1, 7, 1);
    collect(5, "basic");

    // Tie keeps the first occurrence.
    send(3, 5, 0); send(3, 5, 1);
    collect(0, "tie");

    // Forced close after 8 beats; beat 9 waits through a stall.
    for (int i = 0; i < 8; i++) send(15, 7, 0);
    in_valid = 1'b1; in_exp = 4'd3; in_mant = 3'd2; in_last = 1'b1;
    collect(3, "forced");
    send(3, 2, 1);
    collect(0, "beat9");

    // 16-bit instance saturates here, 24-bit does not.
    send(15, 7, 0); send(15, 7, 1);
    collect(1, "sat16");

    // Asynchronous reset mid-frame.
    send(2, 3, 0); send(4, 0, 0);
    #2 rst = 1'b1;
    #1 chk_zero("midrst");
    q_e.delete(); q_m.delete(); frame_forced = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    send(0, 0, 1);
    collect(0, "after_rst");

    // Random frames with gaps.
    for (int f = 0; f < 40; f++) begin
      int  len;
      bit  force_sel;
      len = $urandom_range(1, 8);
      force_sel = (len == 8) && ($urandom_range(0, 1) == 1);
      for (int i = 0; i < len; i++) begin
        int e, m;
        e = (f % 3 == 0) ? $urandom_range(12, 15) : $urandom_range(0, 15);
        m = $urandom_range(0, 7);
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(posedge clk);
        #0;
        send(e, m, (i == len - 1) && !force_sel);
      end
      collect($urandom_range(0, 3), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/softmax_argmax_collector.md
Name: softmax_argmax_collector

Overview:
- Downstream consumer of the pseudo-softmax stage; accepts one (exponent, mantissa) result per class over a short frame.
- Tracks the running maximum and its class index, and accumulates the linear sum of all class values.
- Presents one result record per frame through a valid/ready handshake to the output/LED stage.

Parameters:
MAX_CLASSES, 8, maximum beats per frame; the frame is force-closed at this count
IDX_W, 3, class index width; must satisfy 2**IDX_W >= MAX_CLASSES
SUM_W, 24, linear sum accumulator width; saturating

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  beat valid
in_ready  output  1  block can accept a beat
in_exp  input  4  exponent from pseudo-softmax (exp_out)
in_mant  input  3  mantissa from pseudo-softmax (mant_out)
in_last  input  1  final class of the frame
out_valid  output  1  result record valid
out_ready  input  1  consumer accepts the record
out_idx  output  IDX_W  class index of the maximum
out_exp  output  4  exponent of the maximum
out_mant  output  3  mantissa of the maximum
out_sum  output  SUM_W  saturated linear sum of the frame
out_count  output  IDX_W+1  number of beats in the frame
out_ovf  output  1  frame was force-closed or the sum saturated

Behaviour:
- Clocking and reset: single clock domain. rst is asynchronous and active-high.
- Reset values: state IDLE; in_ready=1; out_valid=0; all other outputs 0.
- Linear value: lin = {1'b1, mant} << exp, giving a 19-bit value. Ordering compares exp first, then mant.
- FSM states are IDLE, ACCUM and HOLD.
- IDLE: in_ready=1. An accepted beat loads max={exp,mant}, idx=0, sum=lin, count=1.
  - If in_last=1, go to HOLD; otherwise go to ACCUM.
- ACCUM: in_ready=1. For each accepted beat:
  - The beat's index is count.
  - max and idx update only when the new value is strictly greater, so the first occurrence wins a tie.
  - sum = min(sum+lin, 2**SUM_W-1); saturation sets a sticky ovf.
  - count increments.
  - Go to HOLD when in_last=1, or when count reaches MAX_CLASSES. A forced close sets ovf.
- HOLD:
  - in_ready=0 and out_valid=1; out_* are registered and stable.
  - On out_valid&&out_ready, go to IDLE. The next cycle has out_valid=0 and in_ready=1; there is no same-cycle bypass.
- Latency: out_valid rises on the first clock edge after the closing beat is accepted.
- Beats presented while in_ready=0 are not consumed; the upstream holds them.
- in_valid=0 gaps inside a frame are allowed, with no timeout.
- Reset mid-frame or mid-HOLD discards everything and returns to the reset values.
- A beat accepted with in_last=1 that also hits MAX_CLASSES closes the frame; ovf is set only when in_last=0.

Optional Feature:
- Macro: SOFTMAX_CONF_FLAG_EN.
- When defined:
  - Adds output out_conf (1 bit), registered with the record.
  - out_conf = 1 when 2*max_lin > sum, i.e. the winner holds a strict majority of the frame mass.
  - out_conf is computed in HOLD entry from the registered max_lin and sum.
  - Reset value of out_conf is 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Shared package softmax_pkg holds:
  - EXP_W=4 and MANT_W=3
  - LIN_W=19
  - a typedef sm_val_t {exp, mant}
  - the FSM state enum
  - function to_linear(sm_val_t)
- One sub-module, sm_val_compare: combinational, giving a strict greater-than of two sm_val_t plus the linear conversion. It is reused by the max tracker.

Test Plan:
- Frame (e2,m3),(e4,m0),(e1,m7) with last on beat 3 → idx=1, exp=4, mant=0, sum=44+128+30=202, count=3, ovf=0.
- Tie: (e3,m5),(e3,m5) with last → idx=0, sum=208, count=2. With SOFTMAX_CONF_FLAG_EN: conf=0 (208 > 208 is false).
- 8 beats of (e15,m7) without last → forced close after beat 8; count=8, ovf=1, sum=3932160 (no saturation). Beat 9 is held with in_ready=0 until the handshake completes.
- out_ready held low for 5 cycles → out_valid and all out_* stay stable and in_ready=0. After out_ready=1, out_valid drops the next cycle and a new frame is accepted.
- rst pulsed mid-frame after 2 beats → outputs zero immediately (asynchronous). A new single-beat frame (e0,m0,last) → idx=0, sum=8, count=1.
- SUM_W=16 with frame (e15,m7),(e15,m7),last → sum=65535, ovf=1, idx=0.
